// File: rtl/f_fetch_unit_pkg.sv
// Shared fetch/decode/CP0 definitions: next-PC select codes, exception
// codes, reset PC and the legal text-segment window.
package f_fetch_unit_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JREG   = 3'd3
  } npc_op_e;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] TEXT_LO_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_DEFAULT  = 32'h0000_6FFC;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // A fetch address is bad if misaligned or outside [lo, hi].
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/f_fetch_unit_npc.sv
// Next-PC selection: computes sequential, branch, jump and register-jump
// targets and picks one according to the control resolved in decode.
// Stall and reset are handled by the PC register in the parent.
module f_npc
  import f_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] d_pc_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_index26_i,
  input  logic [31:0] d_rs_val_i,
  input  logic [2:0]  d_npc_op_i,
  input  logic        d_br_taken_i,
  output logic [31:0] npc_o
);

  logic [31:0] seqPc;
  logic [31:0] dPcPlus4;
  logic [31:0] brOffset;
  logic [31:0] brTarget;
  logic [31:0] jTarget;

  // Targets are relative to the delay-slot address (D's PC + 4); all
  // arithmetic wraps modulo 2^32 and the address check catches the result.
  assign seqPc    = pc_i + 32'd4;
  assign dPcPlus4 = d_pc_i + 32'd4;
  assign brOffset = {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
  assign brTarget = dPcPlus4 + brOffset;
  assign jTarget  = {dPcPlus4[31:28], d_index26_i, 2'b00};

  // Select the next PC; unused op codes fall back to sequential fetch.
  always_comb begin
    npc_o = seqPc;
    case (d_npc_op_i)
      NPC_BRANCH: npc_o = d_br_taken_i ? brTarget : seqPc;
      NPC_JUMP:   npc_o = jTarget;
      NPC_JREG:   npc_o = d_rs_val_i;
      default:    npc_o = seqPc;
    endcase
  end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory, checks the fetch
// address and presents {PC, instruction, exception} to the F/D register.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] TEXT_LO  = TEXT_LO_DEFAULT,
  parameter logic [31:0] TEXT_HI  = TEXT_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs_val,
  input  logic [2:0]  d_npc_op,
  input  logic        d_br_taken,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [4:0]  f_exc,
  output logic        f_we
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] npc;
  logic        addrErr;

  f_npc u_npc (
    .pc_i         (pc_q),
    .d_pc_i       (d_pc),
    .d_imm16_i    (d_imm16),
    .d_index26_i  (d_index26),
    .d_rs_val_i   (d_rs_val),
    .d_npc_op_i   (d_npc_op),
    .d_br_taken_i (d_br_taken),
    .npc_o        (npc)
  );

  // Stall freezes the PC; a redirect seen during a stall is dropped here
  // and re-presented by the held D stage once the stall clears.
  always_comb begin
    pc_d = stall ? pc_q : npc;
  end

  // PC register; reset overrides stall and any redirect.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign addrErr = fetch_addr_err(pc_q, TEXT_LO, TEXT_HI);

  // Output muxing: bad addresses still advance but deliver a NOP plus AdEL.
  always_comb begin
    i_inst_addr = {pc_q[31:2], 2'b00};
    f_pc        = pc_q;
    f_we        = ~stall;
    f_instr     = i_inst_rdata;
    f_exc       = EXC_NONE;
    if (addrErr) begin
      f_instr = NOP_INSTR;
      f_exc   = EXC_ADEL;
    end
  end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a behavioural model.
module tb_f_fetch_unit;

  localparam logic [31:0] LO = 32'h0000_3000;
  localparam logic [31:0] HI = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_rs_val;
  logic [2:0]  d_npc_op;
  logic        d_br_taken;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [4:0]  f_exc;
  logic        f_we;

  int vecCount = 0;
  int missCount = 0;

  f_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .d_pc         (d_pc),
    .d_imm16      (d_imm16),
    .d_index26    (d_index26),
    .d_rs_val     (d_rs_val),
    .d_npc_op     (d_npc_op),
    .d_br_taken   (d_br_taken),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .f_pc         (f_pc),
    .f_instr      (f_instr),
    .f_exc        (f_exc),
    .f_we         (f_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        taken;
    logic [31:0] dpc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] expPc;
    logic [4:0]  expExc;
  } vec_t;

  vec_t vecs[20];

  task automatic applyStimulus(input logic st, input logic [2:0] op, input logic tk,
                               input logic [31:0] dpc, input logic [15:0] imm,
                               input logic [25:0] idx, input logic [31:0] rs,
                               input logic [31:0] rdata);
    stall = st; d_npc_op = op; d_br_taken = tk; d_pc = dpc;
    d_imm16 = imm; d_index26 = idx; d_rs_val = rs; i_inst_rdata = rdata;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected values: PC, exception and write enable come from the caller;
  // instruction and address are derived from the fetch rules.
  task automatic checkOutput(input string name, input logic [31:0] expPc,
                             input logic [4:0] expExc, input logic expWe);
    logic [31:0] expInstr;
    logic [31:0] expAddr;
    expInstr = (expExc == 5'd4) ? 32'h0 : i_inst_rdata;
    expAddr  = expPc & 32'hFFFF_FFFC;
    checkOne({name, ".f_pc"}, f_pc, expPc);
    checkOne({name, ".f_exc"}, {27'd0, f_exc}, {27'd0, expExc});
    checkOne({name, ".f_instr"}, f_instr, expInstr);
    checkOne({name, ".i_inst_addr"}, i_inst_addr, expAddr);
    checkOne({name, ".f_we"}, {31'd0, f_we}, {31'd0, expWe});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] refExc(input logic [31:0] pc);
    if ((pc % 4) != 0 || pc < LO || pc > HI) return 5'd4;
    return 5'd0;
  endfunction

  function automatic logic [31:0] refNext(input logic [31:0] pc, input logic st,
                                          input logic [2:0] op, input logic tk,
                                          input logic [31:0] dpc, input logic [15:0] imm,
                                          input logic [25:0] idx, input logic [31:0] rs);
    longint offset;
    longint target;
    if (st) return pc;
    offset = longint'($signed(imm)) * 4;
    if (op == 3'd1 && tk) begin
      target = longint'(dpc) + 4 + offset;
      return target[31:0];
    end
    if (op == 3'd2) return ((dpc + 32'd4) & 32'hF000_0000) | (32'(idx) * 4);
    if (op == 3'd3) return rs;
    return pc + 32'd4;
  endfunction

  initial begin
    logic [31:0] mpc;
    logic        rst, st, tk;
    logic [2:0]  op;
    logic [31:0] dpc, rs, rdata;
    logic [15:0] imm;
    logic [25:0] idx;

    //         stall op    tk    dpc           imm        idx           rs            expPc         exc
    vecs[0]  = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3000, 5'd0};
    vecs[1]  = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3004, 5'd0};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3008, 5'd0};
    vecs[3]  = '{1'b0, 3'd1, 1'b1, 32'h3004,     16'hFFFF,  26'h0,        32'h0,        32'h0000_300C, 5'd0};
    vecs[4]  = '{1'b0, 3'd1, 1'b0, 32'h3004,     16'hFFFF,  26'h0,        32'h0,        32'h0000_3004, 5'd0};
    vecs[5]  = '{1'b0, 3'd2, 1'b0, 32'h3010,     16'h0,     26'h0000C10,  32'h0,        32'h0000_3008, 5'd0};
    vecs[6]  = '{1'b0, 3'd3, 1'b0, 32'h0,        16'h0,     26'h0,        32'h3001,     32'h0000_3040, 5'd0};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3001, 5'd4};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3005, 5'd4};
    vecs[9]  = '{1'b1, 3'd1, 1'b1, 32'h3004,     16'h0010,  26'h0,        32'h0,        32'h0000_3009, 5'd4};
    vecs[10] = '{1'b1, 3'd1, 1'b1, 32'h3004,     16'h0010,  26'h0,        32'h0,        32'h0000_3009, 5'd4};
    vecs[11] = '{1'b0, 3'd1, 1'b1, 32'h3004,     16'h0010,  26'h0,        32'h0,        32'h0000_3009, 5'd4};
    vecs[12] = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_3048, 5'd0};
    vecs[13] = '{1'b0, 3'd3, 1'b0, 32'h0,        16'h0,     26'h0,        32'h7000,     32'h0000_304C, 5'd0};
    vecs[14] = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_7000, 5'd4};
    vecs[15] = '{1'b0, 3'd3, 1'b0, 32'h0,        16'h0,     26'h0,        32'h2FFC,     32'h0000_7004, 5'd4};
    vecs[16] = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_2FFC, 5'd4};
    vecs[17] = '{1'b0, 3'd3, 1'b0, 32'h0,        16'h0,     26'h0,        32'h6FFC,     32'h0000_3000, 5'd0};
    vecs[18] = '{1'b0, 3'd6, 1'b1, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_6FFC, 5'd0};
    vecs[19] = '{1'b0, 3'd0, 1'b0, 32'h0,        16'h0,     26'h0,        32'h0,        32'h0000_7000, 5'd4};

    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'hDEAD_BEEF);
    tick();
    reset = 1'b0;

    // Directed table; each entry is one cycle, checked before the clock edge.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].op, vecs[i].taken, vecs[i].dpc,
                    vecs[i].imm, vecs[i].idx, vecs[i].rs, 32'h1000_0000 + 32'(i) * 32'h111);
      #2;
      checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expExc, ~vecs[i].stall);
      tick();
    end

    // Reset during a stall with a redirect pending.
    applyStimulus(1'b1, 3'd1, 1'b1, 32'h3004, 16'h0100, 26'h0, 32'h0, 32'h2222_3333);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h4444_5555);
    #2;
    checkOutput("rstDuringStall", 32'h0000_3000, 5'd0, 1'b1);
    tick();

    // Wrap-around past 2^32 stays an address error without side effects.
    applyStimulus(1'b0, 3'd3, 1'b0, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h6666_7777);
    tick();
    applyStimulus(1'b0, 3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 32'h8888_9999);
    #2;
    checkOutput("wrapTop", 32'hFFFF_FFFC, 5'd4, 1'b1);
    tick();
    #2;
    checkOutput("wrapZero", 32'h0000_0000, 5'd4, 1'b1);
    tick();

    // Randomized run against the behavioural model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mpc = 32'h0000_3000;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      op  = 3'($urandom_range(0, 7));
      tk  = 1'($urandom_range(0, 1));
      dpc = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + (32'($urandom_range(0, 16'h3FFF)) & 32'hFFFF_FFFC));
      imm = 16'($urandom);
      idx = ($urandom_range(0, 1) == 0) ? 26'($urandom) : 26'(32'h0C00 + 32'($urandom_range(0, 16'h0FFF)));
      rs  = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16'h4000)));
      rdata = $urandom;
      applyStimulus(st, op, tk, dpc, imm, idx, rs, rdata);
      reset = rst;
      #2;
      checkOutput($sformatf("rand%0d", n), mpc, refExc(mpc), ~st);
      tick();
      mpc = rst ? 32'h0000_3000 : refNext(mpc, st, op, tk, dpc, imm, idx, rs);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/f_fetch_unit.md
# f_fetch_unit

Fetch stage of the five-stage MIPS pipeline. Holds the program counter and selects the next PC from sequential, branch, jump and register-jump targets, using control resolved in D. Drives the external instruction memory address and hands {PC, instruction, exception code} plus a write enable to the F/D pipeline register. Checks fetch-address validity and substitutes a NOP on address errors.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- TEXT_LO, 32'h0000_3000, lowest legal fetch address.
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  from hazard unit; hold PC and F/D contents.
- d_pc  in  32  PC of the instruction currently in D.
- d_imm16  in  16  branch offset field of the D instruction.
- d_index26  in  26  j/jal instr_index field of the D instruction.
- d_rs_val  in  32  forwarded rs value, for jr/jalr.
- d_npc_op  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG; codes 4-7 behave as SEQ.
- d_br_taken  in  1  branch comparison result from D.
- i_inst_addr  out  32  instruction memory address.
- i_inst_rdata  in  32  instruction word, combinational from memory.
- f_pc  out  32  current PC, to F/D.
- f_instr  out  32  fetched instruction or NOP, to F/D.
- f_exc  out  5  0 none, 4 AdEL (fetch address error), to F/D.
- f_we  out  1  F/D write enable, equal to !stall.

## Operation
- Single state register PC; all other outputs combinational from PC, inputs and i_inst_rdata.
- Targets:
  - BRANCH: (d_pc+4) + (sext(d_imm16)<<2).
  - JUMP: {(d_pc+4)[31:28], d_index26, 2'b00}.
  - JREG: d_rs_val, unmodified, no alignment forcing.
- Next-PC priority:
  1. reset → PC_RESET.
  2. stall → PC held.
  3. BRANCH with d_br_taken → branch target.
  4. BRANCH without d_br_taken → PC+4.
  5. JUMP → jump target.
  6. JREG → d_rs_val.
  7. Otherwise → PC+4.
- Delay slot: the instruction in F while the control transfer sits in D is the delay slot; it is always fetched and forwarded. No flush output exists.
- Stall plus redirect in the same cycle: stall wins and the redirect is discarded. Because D is held, the same redirect is re-presented and applied on the first cycle stall is low.
- Address check: error if PC[1:0]≠0, PC<TEXT_LO or PC>TEXT_HI. On error, f_instr=32'h0 and f_exc=4; otherwise f_instr=i_inst_rdata and f_exc=0.
- i_inst_addr={PC[31:2],2'b00} always.
- Next-PC arithmetic is 32-bit modulo 2^32; carries out are dropped and wrap-around produces no error, the address check catches it.
- An erroneous PC still advances normally (PC+4 or redirect).

## Timing
- Reset values (the cycle after reset is sampled high):
  - PC = 0x3000.
  - i_inst_addr = 0x3000.
  - f_pc = 0x3000.
  - f_exc = 0.
  - f_instr = i_inst_rdata.
  - f_we = !stall.
- PC updates on the rising clk edge. A redirect visible in D during cycle n is fetched in cycle n+1.
- Zero-cycle combinational path from i_inst_rdata to f_instr.
- Reset mid-operation overrides stall and any redirect.

## Structure
- Shared package: NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JREG encodings, EXC_NONE=0, EXC_ADEL=4, and the PC_RESET/TEXT bounds defaults, shared with the decode controller and the CP0 block.
- One combinational sub-module, f_npc, computes all targets and the selected next PC. The top level holds the PC register, the address check and the output muxing.

## Test plan
- Reset, then 3 free-running cycles with SEQ → f_pc reads 0x3000, 0x3004, 0x3008, 0x300C; f_exc=0; f_we=1.
- d_pc=0x3004, d_imm16=16'hFFFF, BRANCH, taken → next PC 0x3004. Same inputs with taken=0 → PC+4.
- JUMP with d_pc=0x3010, d_index26=26'h0000C10 → next PC 0x3040.
- JREG with d_rs_val=0x3001 for one cycle (SEQ after) → PC=0x3001, f_instr=0, f_exc=4, i_inst_addr=0x3000; next PC 0x3005, still f_exc=4.
- stall high for 2 cycles while BRANCH taken is presented → PC frozen and f_we=0 during the stall. After stall drops, the redirect is applied exactly once.
- JREG to 0x7000, then JREG to 0x2FFC → f_exc=4 in both cases. Reset asserted during stall → PC=0x3000 next cycle.
